// File: rtl/mix_columns_unit.sv
// AES MixColumns / InvMixColumns stage with valid/ready handshakes and a column-serial datapath.
// COLS_PER_CYCLE columns are transformed per cycle; the result is held in a register under backpressure.
module mix_columns_unit #(
  parameter int unsigned COLS_PER_CYCLE = 4,
  parameter bit          ENABLE_INV     = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : gen_bad_cols
    $error("mix_columns_unit: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] Step    = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LastCnt = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [127:0]   in_q, in_d;
  logic           inv_q, inv_d;
  logic [127:0]   out_q, out_d;

  function automatic logic [7:0] xtime(input logic [7:0] c);
    return {c[6:0], 1'b0} ^ (c[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte 0 of a column sits in the most significant byte.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] r  [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    if (inv) begin
      r[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      r[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      r[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      r[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end else begin
      // 3x = 2x ^ x
      r[0] = x2[0] ^ x2[1] ^ a[1] ^ a[2] ^ a[3];
      r[1] = a[0] ^ x2[1] ^ x2[2] ^ a[2] ^ a[3];
      r[2] = a[0] ^ a[1] ^ x2[2] ^ x2[3] ^ a[3];
      r[3] = x2[0] ^ a[0] ^ a[1] ^ a[2] ^ x2[3];
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  always_comb begin
    logic [1:0] col_idx;
    col_idx  = 2'd0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_d     = in_q;
    inv_d    = inv_q;
    out_d    = out_q;
    in_ready = 1'b0;

    unique case (state_q)
      StIdle: in_ready = 1'b1;
      StRun: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          col_idx = cnt_q + 2'(k);
          out_d[{col_idx, 5'd0} +: 32] = mix_col(in_q[{col_idx, 5'd0} +: 32], inv_q);
        end
        cnt_d = cnt_q + Step;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Output handshake and a new acceptance may share the same edge.
        in_ready = out_ready;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (in_valid && in_ready) begin
      in_d    = in_state;
      inv_d   = ENABLE_INV ? in_inv : 1'b0;
      cnt_d   = 2'd0;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      in_q    <= '0;
      inv_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      inv_q   <= inv_d;
      out_q   <= out_d;
    end
  end

  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_state = out_q;

endmodule
